// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned NumReq         = 2;
  localparam int unsigned CntW           = 4;
  localparam int unsigned DefaultTimeout = 15;

  // Requester indices as carried in the owner / last-granted registers.
  localparam logic ReqCpu = 1'b0;
  localparam logic ReqDma = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StBusy,
    StResp
  } arb_state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sign_mask;
  } mem_req_t;

  function automatic logic [NumReq-1:0] req_onehot(input logic idx);
    return (idx == ReqDma) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational 2-way grant: round-robin against the last-granted requester, or fixed
// priority to requester 0 when RoundRobin is 0.
module rr_arbiter2
  import dmem_arb_pkg::*;
#(
  parameter int unsigned RoundRobin = 1
) (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o,
  output logic       idx_o
);

  logic prefer_dma;

  // On contention the DMA side wins only if the CPU was served last.
  assign prefer_dma = (RoundRobin != 0) && (last_i == ReqCpu);

  always_comb begin
    gnt_o = 2'b00;
    idx_o = ReqCpu;
    case (req_i)
      2'b01: begin
        gnt_o = 2'b01;
        idx_o = ReqCpu;
      end
      2'b10: begin
        gnt_o = 2'b10;
        idx_o = ReqDma;
      end
      2'b11: begin
        if (prefer_dma) begin
          gnt_o = 2'b10;
          idx_o = ReqDma;
        end else begin
          gnt_o = 2'b01;
          idx_o = ReqCpu;
        end
      end
      default: begin
        gnt_o = 2'b00;
        idx_o = ReqCpu;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates CPU and DMA accesses onto one data memory port; one transaction in flight,
// completion signalled by the stall line falling, aborted after TIMEOUT busy cycles.
module data_mem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 1,
  parameter int unsigned TIMEOUT     = DefaultTimeout
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic [1:0]  rq_valid_i,
  input  logic        rq0_write_i,
  input  logic        rq1_write_i,
  input  logic [31:0] rq0_addr_i,
  input  logic [31:0] rq1_addr_i,
  input  logic [31:0] rq0_wdata_i,
  input  logic [31:0] rq1_wdata_i,
  input  logic [3:0]  rq0_sign_mask_i,
  input  logic [3:0]  rq1_sign_mask_i,
  output logic [1:0]  rq_ready_o,

  output logic [1:0]  rs_valid_o,
  output logic [31:0] rs_rdata_o,
  output logic        rs_err_o,

  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_write_data_o,
  output logic [3:0]  mem_sign_mask_o,
  output logic        mem_memread_o,
  output logic        mem_memwrite_o,
  input  logic [31:0] mem_read_data_i,
  input  logic        mem_clk_stall_i
);

  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  arb_state_e      state_q, state_d;
  mem_req_t        req_q, req_d, req_sel;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic            seen_q, seen_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]     rdata_q, rdata_d;

  logic [1:0]      gnt;
  logic            gnt_idx;

  rr_arbiter2 #(
    .RoundRobin(ROUND_ROBIN)
  ) u_arb (
    .req_i (rq_valid_i),
    .last_i(last_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  always_comb begin
    if (gnt_idx == ReqDma) begin
      req_sel.write     = rq1_write_i;
      req_sel.addr      = rq1_addr_i;
      req_sel.wdata     = rq1_wdata_i;
      req_sel.sign_mask = rq1_sign_mask_i;
    end else begin
      req_sel.write     = rq0_write_i;
      req_sel.addr      = rq0_addr_i;
      req_sel.wdata     = rq0_wdata_i;
      req_sel.sign_mask = rq0_sign_mask_i;
    end
  end

  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    owner_d = owner_q;
    last_d  = last_q;
    seen_d  = seen_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (|rq_valid_i) begin
          owner_d = gnt_idx;
          req_d   = req_sel;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        seen_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
        state_d = StBusy;
      end
      StBusy: begin
        cnt_d  = cnt_inc;
        seen_d = seen_q | mem_clk_stall_i;
        // Completion needs a full high-then-low stall sequence; it beats a same-cycle timeout.
        if (seen_q && !mem_clk_stall_i) begin
          rdata_d = req_q.write ? '0 : mem_read_data_i;
          state_d = StResp;
        end else if (cnt_inc == TimeoutCnt) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      req_q   <= '0;
      owner_q <= ReqCpu;
      last_q  <= ReqDma;
      seen_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Accept is the only output that looks at inputs directly: grant happens in the IDLE cycle.
  assign rq_ready_o       = (state_q == StIdle) ? gnt : 2'b00;

  assign mem_addr_o       = (state_q != StIdle) ? req_q.addr      : '0;
  assign mem_write_data_o = (state_q != StIdle) ? req_q.wdata     : '0;
  assign mem_sign_mask_o  = (state_q != StIdle) ? req_q.sign_mask : '0;
  assign mem_memread_o    = (state_q == StIssue) && !req_q.write;
  assign mem_memwrite_o   = (state_q == StIssue) &&  req_q.write;

  assign rs_valid_o       = (state_q == StResp) ? req_onehot(owner_q) : 2'b00;
  assign rs_rdata_o       = (state_q == StResp) ? rdata_q : '0;
  assign rs_err_o         = (state_q == StResp) && err_q;

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter: ROUND_ROBIN, default 1, 1 = round-robin between requesters, 0 = fixed priority to requester 0.
REQ-002 Parameter: TIMEOUT, default 15, maximum BUSY cycles before abort (4-bit counter, range 3..15).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 rq_valid  in  2  per-requester request (bit0 = CPU, bit1 = DMA); must be held with its fields until the matching rq_ready pulse.
REQ-006 rq0_write/rq1_write  in  1  1 = store, 0 = load.
REQ-007 rq0_addr/rq1_addr  in  32  byte address.
REQ-008 rq0_wdata/rq1_wdata  in  32  store data.
REQ-009 rq0_sign_mask/rq1_sign_mask  in  4  size/sign code, passed to memory unchanged.
REQ-010 rq_ready  out  2  one-cycle accept pulse, one-hot or zero.
REQ-011 rs_valid  out  2  one-cycle completion pulse to the owning requester.
REQ-012 rs_rdata  out  32  load data, valid while rs_valid is non-zero.
REQ-013 rs_err  out  1  qualifies rs_valid: transaction aborted by timeout.
REQ-014 mem_addr, mem_write_data, mem_sign_mask  out  32/32/4  memory request fields.
REQ-015 mem_memread, mem_memwrite  out  1  memory strobes.
REQ-016 mem_read_data  in  32  memory load data.
REQ-017 mem_clk_stall  in  1  memory busy indication.

Function
REQ-018 FSM states: IDLE, ISSUE, BUSY, RESP.
REQ-019 IDLE: if any rq_valid bit is set, grant one requester, latch its fields, pulse its rq_ready in the same cycle, and move to ISSUE.
REQ-020 Round-robin: when both requesters are valid, grant the one not granted last; after reset, requester 0 wins. Fixed mode: requester 0 always wins.
REQ-021 ISSUE lasts exactly 1 cycle: drive the latched fields and assert exactly one strobe (mem_memread for a load, mem_memwrite for a store); go to BUSY. Strobes are 0 in every other state.
REQ-022 mem_addr, mem_write_data, mem_sign_mask hold the latched values in ISSUE, BUSY and RESP, and are 0 in IDLE.
REQ-023 BUSY: record that mem_clk_stall has been seen high; once it has been seen high and then reads 0, capture mem_read_data (loads) and go to RESP.
REQ-024 BUSY: the counter increments every cycle; on reaching TIMEOUT, go to RESP with rs_err = 1 and rs_rdata = 0.
REQ-025 RESP lasts 1 cycle: pulse rs_valid for the owner; rs_rdata is the captured data for loads and 0 for stores; record the owner as last-granted; return to IDLE.
REQ-026 Latency with memory stalling 2 cycles: rq_ready at cycle t, strobe at t+1, rs_valid at t+5.
REQ-027 No new grant is made outside IDLE; a requester may raise rq_valid at any time, and a request arriving during RESP is granted in the following IDLE cycle.
REQ-028 rs_valid is 0 in every state except RESP, and rs_err is 0 whenever rs_valid is 0.

Reset
REQ-029 Reset is asynchronous: FSM = IDLE, last-granted = 1, counter and stall-seen flag cleared, all outputs 0.
REQ-030 Reset asserted mid-transaction abandons it with no rs_valid pulse; the first request after reset is re-arbitrated from IDLE.

Structure
REQ-031 The FSM state encoding, requester index constants and the default TIMEOUT belong in the shared package dmem_arb_pkg.
REQ-032 One sub-module: rr_arbiter2, a combinational 2-way grant with a last-granted input; the FSM, latches and counter stay in data_mem_arbiter.

Verification
REQ-033 Lone CPU load from 0x1004, memory returns 0xDEADBEEF after a 2-cycle stall -> rq_ready = 01; one mem_memread pulse; rs_valid = 01 with rdata 0xDEADBEEF at t+5.
REQ-034 Both requesters valid continuously for 4 transactions -> grant order 0,1,0,1 (ROUND_ROBIN = 1); with ROUND_ROBIN = 0 -> 0,0,0,0.
REQ-035 DMA store of 0x12345678 to 0x2000 -> one mem_memwrite pulse with that address and data; rs_valid = 10, rs_rdata = 0, rs_err = 0.
REQ-036 mem_clk_stall never rises after the strobe, TIMEOUT = 15 -> rs_valid with rs_err = 1 and rs_rdata = 0; next request proceeds normally.
REQ-037 rst_n driven low during BUSY -> all outputs 0 immediately, no rs_valid; a request after release is granted to requester 0.
REQ-038 Request raised during RESP -> no grant in RESP; rq_ready pulses in the next cycle.
